// File: rtl/serial_magnitude_comparator_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_magnitude_comparator_if                                        |
// | Digit-stream handshake and L/E/G result bundle for the comparator.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface serial_magnitude_comparator_if #(
  parameter int D = 1
);
  logic         start;
  logic         signed_mode;
  logic         lsb_first;
  logic         in_valid;
  logic [D-1:0] a_in;
  logic [D-1:0] b_in;
  logic         abort;
  logic         busy;
  logic         done;
  logic         L;
  logic         E;
  logic         G;

  modport master (
    output start, signed_mode, lsb_first, in_valid, a_in, b_in, abort,
    input  busy, done, L, E, G
  );

  modport slave (
    input  start, signed_mode, lsb_first, in_valid, a_in, b_in, abort,
    output busy, done, L, E, G
  );
endinterface
`default_nettype wire

// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | serial_magnitude_comparator                                           |
// | Digit-serial signed/unsigned magnitude compare, MSB- or LSB-first.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module serial_magnitude_comparator #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  serial_magnitude_comparator_if.slave   bus
);
  localparam int            N           = W / D;
  localparam int            CW          = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST      = CW'(N - 1);
  localparam logic [D-1:0]  C_SIGN_MASK = D'(1) << (D - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_signed;
  logic          r_lsb;
  rel_t          r_rel;
  rel_t          w_dig_rel;
  rel_t          w_rel_nxt;
  logic          r_l;
  logic          r_e;
  logic          r_g;
  logic          w_start_acc;
  logic          w_consume;
  logic          w_last;
  logic          w_flip;
  logic [D-1:0]  w_a;
  logic [D-1:0]  w_b;

  assign w_start_acc = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_consume   = (r_state == S_RUN) && bus.in_valid && !bus.abort;
  assign w_last      = w_consume && (r_cnt == C_LAST);

  // Offset-binary on the sign digit turns the unsigned digit compare into a signed one.
  always_comb begin
    w_flip    = r_signed && (r_lsb ? (r_cnt == C_LAST) : (r_cnt == '0));
    w_a       = bus.a_in ^ (w_flip ? C_SIGN_MASK : '0);
    w_b       = bus.b_in ^ (w_flip ? C_SIGN_MASK : '0);
    w_dig_rel = REL_EQ;
    if (w_a < w_b) begin
      w_dig_rel = REL_LT;
    end else if (w_a > w_b) begin
      w_dig_rel = REL_GT;
    end
    w_rel_nxt = r_rel;
    if (r_lsb) begin
      if (w_dig_rel != REL_EQ) begin
        w_rel_nxt = w_dig_rel;
      end
    end else if (r_rel == REL_EQ) begin
      w_rel_nxt = w_dig_rel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_acc) w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_signed <= 1'b0;
      r_lsb    <= 1'b0;
      r_rel    <= REL_EQ;
      r_l      <= 1'b0;
      r_e      <= 1'b0;
      r_g      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_signed <= bus.signed_mode;
        r_lsb    <= bus.lsb_first;
        r_cnt    <= '0;
        r_rel    <= REL_EQ;
        r_l      <= 1'b0;
        r_e      <= 1'b0;
        r_g      <= 1'b0;
      end else if (bus.abort && (r_state != S_IDLE)) begin
        r_l <= 1'b0;
        r_e <= 1'b0;
        r_g <= 1'b0;
      end else if (w_consume) begin
        r_cnt <= r_cnt + CW'(1);
        r_rel <= w_rel_nxt;
        if (w_last) begin
          r_l <= (w_rel_nxt == REL_LT);
          r_e <= (w_rel_nxt == REL_EQ);
          r_g <= (w_rel_nxt == REL_GT);
        end
      end
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.L    = r_l;
  assign bus.E    = r_e;
  assign bus.G    = r_g;
endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_serial_magnitude_comparator                                        |
// | Directed + random checks of W=8 comparators with D=1, D=4 and D=8.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic       t_start, t_signed, t_lsb, t_valid, t_abort;
  logic [7:0] t_a, t_b;
  logic       o_busy, o_done, o_l, o_e, o_g;

  serial_magnitude_comparator_if #(.D(1)) if1 ();
  serial_magnitude_comparator_if #(.D(4)) if4 ();
  serial_magnitude_comparator_if #(.D(8)) if8 ();

  assign if1.start = t_start & (sel == 0);
  assign if1.in_valid = t_valid & (sel == 0);
  assign if1.abort = t_abort & (sel == 0);
  assign if1.signed_mode = t_signed;
  assign if1.lsb_first = t_lsb;
  assign if1.a_in = t_a[0:0];
  assign if1.b_in = t_b[0:0];

  assign if4.start = t_start & (sel == 1);
  assign if4.in_valid = t_valid & (sel == 1);
  assign if4.abort = t_abort & (sel == 1);
  assign if4.signed_mode = t_signed;
  assign if4.lsb_first = t_lsb;
  assign if4.a_in = t_a[3:0];
  assign if4.b_in = t_b[3:0];

  assign if8.start = t_start & (sel == 2);
  assign if8.in_valid = t_valid & (sel == 2);
  assign if8.abort = t_abort & (sel == 2);
  assign if8.signed_mode = t_signed;
  assign if8.lsb_first = t_lsb;
  assign if8.a_in = t_a;
  assign if8.b_in = t_b;

  serial_magnitude_comparator #(.W(8), .D(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  serial_magnitude_comparator #(.W(8), .D(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  serial_magnitude_comparator #(.W(8), .D(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  always_comb begin
    o_busy = if1.busy; o_done = if1.done; o_l = if1.L; o_e = if1.E; o_g = if1.G;
    if (sel == 1) begin
      o_busy = if4.busy; o_done = if4.done; o_l = if4.L; o_e = if4.E; o_g = if4.G;
    end else if (sel == 2) begin
      o_busy = if8.busy; o_done = if8.done; o_l = if8.L; o_e = if8.E; o_g = if8.G;
    end
  end

  function automatic logic [7:0] outs();
    return {3'b000, o_busy, o_done, o_l, o_e, o_g};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (sel=%0d)", tag, obs, exp, sel);
    end
  endtask

  // Reference: whole-operand integer compare, returns {L,E,G}.
  function automatic logic [2:0] ref_leg(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int ia, ib;
    if (sg) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    if (ia < ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [7:0] digit(input logic [7:0] v, input int dw, input int k, input logic ls);
    int nd, idx;
    logic [7:0] m;
    nd  = 8 / dw;
    idx = ls ? k : (nd - 1 - k);
    m   = (dw == 8) ? 8'hFF : ((8'd1 << dw) - 8'd1);
    return (v >> (idx * dw)) & m;
  endfunction

  // mode: 0 normal, 1 start held from the done cycle, 2 abort in the done cycle
  task automatic compare(input int ds, input logic [7:0] a, input logic [7:0] b,
                         input logic sg, input logic ls, input int mode,
                         input int stall_at, input int stall_len, input int stall_pct);
    int dw, nd, k, stalled;
    logic v;
    logic [2:0] leg;
    dw  = (ds == 0) ? 1 : (ds == 1) ? 4 : 8;
    nd  = 8 / dw;
    leg = ref_leg(a, b, sg);
    sel = ds;
    t_start = 1'b1; t_signed = sg; t_lsb = ls; t_valid = 1'b1;
    t_a = 8'($urandom); t_b = 8'($urandom);
    @(negedge clk);
    check("start_accept", outs(), 8'h10);
    k = 0;
    stalled = 0;
    while (k < nd) begin
      if (k == stall_at && stalled < stall_len) begin
        v = 1'b0;
        stalled++;
      end else begin
        v = (int'($urandom_range(99, 0)) >= stall_pct);
      end
      t_valid = v;
      t_start = 1'($urandom_range(1, 0));
      if (v) begin
        t_a = digit(a, dw, k, ls);
        t_b = digit(b, dw, k, ls);
      end else begin
        t_a = 8'($urandom);
        t_b = 8'($urandom);
      end
      @(negedge clk);
      if (v) k++;
      if (k < nd) check("run", outs(), 8'h10);
    end
    t_valid = 1'b0;
    t_start = (mode == 1);
    t_abort = (mode == 2);
    check("done", outs(), {3'b000, 2'b01, leg});
    @(negedge clk);
    t_abort = 1'b0;
    if (mode == 2) check("abort_in_done", outs(), 8'h00);
    else check("hold", outs(), {5'b00000, leg});
  endtask

  task automatic interrupt(input logic use_rst);
    string tag;
    tag = use_rst ? "rst_mid" : "abort_mid";
    sel = 0;
    t_start = 1'b1; t_signed = 1'b0; t_lsb = 1'b0; t_valid = 1'b0;
    @(negedge clk);
    t_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_valid = 1'b1; t_a = 8'($urandom); t_b = 8'($urandom);
      @(negedge clk);
    end
    if (use_rst) rst = 1'b1;
    else t_abort = 1'b1;
    @(negedge clk);
    check(tag, outs(), 8'h00);
    rst = 1'b0;
    t_abort = 1'b0;
    for (int i = 0; i < 10; i++) begin
      t_valid = 1'b1; t_a = 8'($urandom); t_b = 8'($urandom);
      @(negedge clk);
      check("no_done", outs(), 8'h00);
    end
    t_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    int rd;
    rst = 1'b1;
    t_start = 1'b0; t_signed = 1'b0; t_lsb = 1'b0; t_valid = 1'b0; t_abort = 1'b0;
    t_a = 8'h00; t_b = 8'h00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset", outs(), 8'h00);
    end
    rst = 1'b0;
    @(negedge clk);

    compare(0, 8'hA5, 8'h5A, 1'b0, 1'b0, 0, -1, 0, 0);
    compare(0, 8'hA5, 8'h5A, 1'b1, 1'b0, 0, -1, 0, 0);
    compare(1, 8'h80, 8'h7F, 1'b1, 1'b1, 0, -1, 0, 0);
    compare(1, 8'h12, 8'h21, 1'b0, 1'b1, 0, -1, 0, 0);
    compare(1, 8'h3C, 8'h3C, 1'b0, 1'b1, 0, -1, 0, 0);
    compare(0, 8'hA5, 8'h5A, 1'b0, 1'b0, 0, 4, 3, 0);

    interrupt(1'b1);
    interrupt(1'b0);
    sel = 0; t_start = 1'b1; t_abort = 1'b1;
    @(negedge clk);
    check("abort_idle", {7'b0, o_busy}, 8'h00);
    t_start = 1'b0; t_abort = 1'b0;
    compare(0, 8'h00, 8'h00, 1'b0, 1'b0, 0, -1, 0, 0);

    compare(0, 8'h33, 8'h44, 1'b0, 1'b1, 1, -1, 0, 0);
    compare(0, 8'hF0, 8'h0F, 1'b1, 1'b0, 0, -1, 0, 0);
    compare(1, 8'h9C, 8'h9B, 1'b0, 1'b0, 2, -1, 0, 0);
    compare(2, 8'h80, 8'h7F, 1'b1, 1'b0, 0, -1, 0, 0);
    compare(2, 8'h80, 8'h7F, 1'b0, 1'b1, 0, -1, 0, 0);
    compare(2, 8'h42, 8'h42, 1'b1, 1'b1, 0, -1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      rd = int'($urandom_range(2, 0));
      ra = 8'($urandom);
      case ($urandom_range(2, 0))
        0:       rb = ra;
        1:       rb = ra ^ 8'h80;
        default: rb = 8'($urandom);
      endcase
      compare(rd, ra, rb, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 0, -1, 0, 30);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
